// File: rtl/tm1638_source_scheduler_pkg.sv
// rtl/tm1638_source_scheduler_pkg.sv - shared frame and scheduler types for the tm1638 source scheduler
package tm1638_source_scheduler_pkg;

  // Eight digits of eight segments each, and the eight discrete LEDs.
  typedef logic [63:0] segments_t;
  typedef logic [7:0]  leds_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } sched_state_t;

  typedef struct packed {
    segments_t seg;
    leds_t     leds;
  } frame_t;

  // Frame pushed to the driver when the display is blanked on a source change.
  localparam frame_t BLANK_FRAME = '0;

endpackage

// File: rtl/tm1638_source_scheduler_if.sv
// rtl/tm1638_source_scheduler_if.sv - source-side and driver-side signal bundle of the scheduler
interface tm1638_source_scheduler_if #(
  parameter int NUM_SRC = 8
);
  import tm1638_source_scheduler_pkg::*;

  localparam int SEL_W = $clog2(NUM_SRC);

  // Source side
  segments_t          i_Segments [NUM_SRC];
  leds_t              i_Leds     [NUM_SRC];
  logic [NUM_SRC-1:0] i_Valid;
  logic               i_Next;
  logic               i_Auto_En;
  logic               i_Driver_Busy;

  // Driver side
  segments_t          o_Segments;
  leds_t              o_Leds;
  logic               o_Valid;
  logic [SEL_W-1:0]   o_Sel;
  logic [15:0]        o_Drop_Count;

  // Environment: sources, buttons and the driver.
  modport master (
    output i_Segments, i_Leds, i_Valid, i_Next, i_Auto_En, i_Driver_Busy,
    input  o_Segments, o_Leds, o_Valid, o_Sel, o_Drop_Count
  );

  // The scheduler itself.
  modport slave (
    input  i_Segments, i_Leds, i_Valid, i_Next, i_Auto_En, i_Driver_Busy,
    output o_Segments, o_Leds, o_Valid, o_Sel, o_Drop_Count
  );

endinterface

// File: rtl/tm1638_sel_rotator.sv
// rtl/tm1638_sel_rotator.sv - source selection register with manual advance and auto-rotate timer
module tm1638_sel_rotator #(
  parameter int NUM_SRC     = 8,
  parameter int INIT_SEL    = 6,
  parameter int AUTO_CYCLES = 27_000_000,
  localparam int SEL_W      = $clog2(NUM_SRC)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Next,
  input  logic             i_Auto_En,
  output logic [SEL_W-1:0] sel,
  output logic             switch_stb
);

  localparam int               AUTO_W    = $clog2(AUTO_CYCLES);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_SRC - 1);
  localparam logic [SEL_W-1:0]  SEL_INIT  = SEL_W'(INIT_SEL);

  logic [AUTO_W-1:0] auto_cnt;
  logic              auto_tick;
  logic              advance;

  // A manual pulse and an auto tick landing together still move by one.
  always_comb begin
    auto_tick = i_Auto_En && (auto_cnt == AUTO_LAST);
    advance   = i_Next || auto_tick;
  end

  assign switch_stb = advance;

  // Selection wraps to 0 after the last source; the timer restarts on every advance.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sel      <= SEL_INIT;
      auto_cnt <= '0;
    end else begin
      if (advance) begin
        sel <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
      end
      if (!i_Auto_En || advance) begin
        auto_cnt <= '0;
      end else begin
        auto_cnt <= auto_cnt + AUTO_W'(1);
      end
    end
  end

endmodule

// File: rtl/tm1638_source_scheduler.sv
// rtl/tm1638_source_scheduler.sv - captures frames from the selected source and paces them into the tm1638 driver
module tm1638_source_scheduler
  import tm1638_source_scheduler_pkg::*;
#(
  parameter int NUM_SRC         = 8,
  parameter int INIT_SEL        = 6,
  parameter int MIN_GAP_CYCLES  = 16,
  parameter int AUTO_CYCLES     = 27_000_000,
  parameter int BLANK_ON_SWITCH = 1
) (
  input logic                     i_Clk,
  input logic                     i_Rst,
  tm1638_source_scheduler_if.slave bus
);

  localparam int              SEL_W    = $clog2(NUM_SRC);
  localparam int              GAP_W    = (MIN_GAP_CYCLES > 1) ? $clog2(MIN_GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP_CYCLES - 1);

  logic [SEL_W-1:0] sel;
  logic             switch_stb;

  sched_state_t     state;
  sched_state_t     next_state;

  frame_t           in_frame;
  logic             in_valid;
  logic             capture;
  logic             ready;

  frame_t           pend_frame;
  logic             pending;
  frame_t           out_frame;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      drop_cnt;

  logic             issue;
  logic             load;

  tm1638_sel_rotator #(
    .NUM_SRC    (NUM_SRC),
    .INIT_SEL   (INIT_SEL),
    .AUTO_CYCLES(AUTO_CYCLES)
  ) u_rotator (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Next    (bus.i_Next),
    .i_Auto_En (bus.i_Auto_En),
    .sel       (sel),
    .switch_stb(switch_stb)
  );

  // Look at the selected source only; its strobe is dropped in the cycle the selection moves.
  always_comb begin
    in_frame.seg  = bus.i_Segments[sel];
    in_frame.leds = bus.i_Leds[sel];
    in_valid      = bus.i_Valid[sel];
    capture       = in_valid && !switch_stb;
    ready         = pending && !bus.i_Driver_Busy;
  end

  // Scheduler state register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: the last gap cycle hands straight to an issue so pulses sit MIN_GAP_CYCLES+1 apart.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (ready) next_state = S_ISSUE;
      S_ISSUE: next_state = S_GAP;
      S_GAP:   if (gap_cnt == '0) next_state = ready ? S_ISSUE : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs of the FSM: the strobe while issuing and the output-register load just before it.
  always_comb begin
    issue = (state == S_ISSUE);
    load  = (next_state == S_ISSUE);
  end

  // Pending buffer: a switch discards it (optionally arming a blank), captures overwrite, a load consumes it.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      pend_frame <= '0;
      pending    <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (switch_stb) begin
        pend_frame <= BLANK_FRAME;
        pending    <= (BLANK_ON_SWITCH != 0);
      end else if (capture) begin
        pend_frame <= in_frame;
        pending    <= 1'b1;
        if (pending && !load && (drop_cnt != 16'hFFFF)) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end else if (load) begin
        pending <= 1'b0;
      end
    end
  end

  // Output frame register and inter-frame gap counter.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      out_frame <= '0;
      gap_cnt   <= '0;
    end else begin
      if (load) begin
        out_frame <= pend_frame;
      end
      if (state == S_ISSUE) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == S_GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  assign bus.o_Segments   = out_frame.seg;
  assign bus.o_Leds       = out_frame.leds;
  assign bus.o_Valid      = issue;
  assign bus.o_Sel        = sel;
  assign bus.o_Drop_Count = drop_cnt;

endmodule

// File: tb/tb_tm1638_source_scheduler.sv
// tb/tb_tm1638_source_scheduler.sv - directed self-checking bench for tm1638_source_scheduler
module tb_tm1638_source_scheduler;
  import tm1638_source_scheduler_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   n;
  int   c1;
  int   c2;

  tm1638_source_scheduler_if #(.NUM_SRC(8)) bus ();

  tm1638_source_scheduler #(
    .NUM_SRC        (8),
    .INIT_SEL       (6),
    .MIN_GAP_CYCLES (16),
    .AUTO_CYCLES    (10),
    .BLANK_ON_SWITCH(1)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Steps until o_Valid is seen; returns the number of steps taken or -1.
  task automatic wait_valid(input int max, output int steps);
    steps = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (bus.o_Valid === 1'b1) begin
        steps = i;
        break;
      end
    end
  endtask

  task automatic count_valids(input int k, output int cnt);
    cnt = 0;
    for (int i = 0; i < k; i++) begin
      step();
      if (bus.o_Valid === 1'b1) cnt++;
    end
  endtask

  task automatic strobe(input int src, input logic [63:0] seg, input logic [7:0] leds);
    bus.i_Segments[src] = seg;
    bus.i_Leds[src]     = leds;
    bus.i_Valid[src]    = 1'b1;
    step();
    bus.i_Valid[src]    = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b1;
    for (int s = 0; s < 8; s++) begin
      bus.i_Segments[s] = '0;
      bus.i_Leds[s]     = '0;
    end
    bus.i_Valid       = '0;
    bus.i_Next        = 1'b0;
    bus.i_Auto_En     = 1'b0;
    bus.i_Driver_Busy = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", 64'(bus.o_Valid), 64'd0);
    chk("rst_sel", 64'(bus.o_Sel), 64'd6);
    chk("rst_drop", 64'(bus.o_Drop_Count), 64'd0);
    chk("rst_seg", bus.o_Segments, 64'd0);
    rst = 1'b0;
    step();
    step();

    // Capture to issue latency is two cycles
    strobe(6, 64'hA1A2_A3A4_A5A6_A7A8, 8'h5A);
    chk("lat1_valid", 64'(bus.o_Valid), 64'd0);
    step();
    chk("lat2_valid", 64'(bus.o_Valid), 64'd1);
    chk("lat2_seg", bus.o_Segments, 64'hA1A2_A3A4_A5A6_A7A8);
    chk("lat2_leds", 64'(bus.o_Leds), 64'h5A);
    chk("lat2_sel", 64'(bus.o_Sel), 64'd6);
    c1 = cyc;

    // Second strobe three cycles later waits out the gap
    step();
    strobe(6, 64'hB0B0_0000_1111_2222, 8'h3C);
    wait_valid(40, n);
    c2 = cyc;
    chk("gap_spacing", 64'(c2 - c1), 64'd17);
    chk("gap_seg", bus.o_Segments, 64'hB0B0_0000_1111_2222);
    chk("gap_drop", 64'(bus.o_Drop_Count), 64'd0);
    count_valids(20, n);
    chk("gap_quiet", 64'(n), 64'd0);

    // Busy stalls issue; overwrites are counted as drops; latest frame wins
    bus.i_Driver_Busy = 1'b1;
    strobe(6, 64'h0000_0000_0000_00AA, 8'h01);
    step();
    step();
    strobe(6, 64'h0000_0000_0000_00BB, 8'h02);
    step();
    strobe(6, 64'h0000_0000_0000_00CC, 8'h03);
    count_valids(6, n);
    chk("busy_novalid", 64'(n), 64'd0);
    chk("busy_drop", 64'(bus.o_Drop_Count), 64'd2);
    bus.i_Driver_Busy = 1'b0;
    wait_valid(5, n);
    chk("busy_rel_lat", 64'(n), 64'd1);
    chk("busy_rel_seg", bus.o_Segments, 64'h0000_0000_0000_00CC);
    chk("busy_rel_leds", 64'(bus.o_Leds), 64'h03);
    count_valids(30, n);
    chk("busy_single", 64'(n), 64'd0);

    // Manual advance 6 -> 7 issues a blank frame
    bus.i_Next = 1'b1;
    step();
    bus.i_Next = 1'b0;
    chk("sw67_sel", 64'(bus.o_Sel), 64'd7);
    wait_valid(5, n);
    chk("sw67_lat", 64'(n), 64'd1);
    chk("sw67_seg", bus.o_Segments, 64'd0);
    count_valids(25, n);
    chk("sw67_quiet", 64'(n), 64'd0);
    strobe(7, 64'hDDDD_0000_DDDD_0000, 8'hD7);
    wait_valid(5, n);
    chk("src7_lat", 64'(n), 64'd1);
    chk("src7_seg", bus.o_Segments, 64'hDDDD_0000_DDDD_0000);
    count_valids(25, n);
    chk("src7_quiet", 64'(n), 64'd0);

    // Wrap 7 -> 0 with a coincident source-7 strobe that must be ignored
    bus.i_Next           = 1'b1;
    bus.i_Segments[7]    = 64'hEEEE_EEEE_EEEE_EEEE;
    bus.i_Leds[7]        = 8'hEE;
    bus.i_Valid[7]       = 1'b1;
    step();
    bus.i_Next           = 1'b0;
    bus.i_Valid[7]       = 1'b0;
    chk("wrap_sel", 64'(bus.o_Sel), 64'd0);
    wait_valid(5, n);
    chk("wrap_lat", 64'(n), 64'd1);
    chk("wrap_seg", bus.o_Segments, 64'd0);
    chk("wrap_leds", 64'(bus.o_Leds), 64'd0);
    count_valids(30, n);
    chk("wrap_quiet", 64'(n), 64'd0);
    chk("wrap_drop", 64'(bus.o_Drop_Count), 64'd2);

    // Auto-rotate with a coincident manual pulse on the tenth cycle
    bus.i_Auto_En = 1'b1;
    repeat (9) step();
    chk("auto_pre", 64'(bus.o_Sel), 64'd0);
    bus.i_Next = 1'b1;
    step();
    bus.i_Next = 1'b0;
    chk("auto_merge", 64'(bus.o_Sel), 64'd1);
    repeat (9) step();
    chk("auto_hold", 64'(bus.o_Sel), 64'd1);
    step();
    chk("auto_tick", 64'(bus.o_Sel), 64'd2);
    bus.i_Auto_En = 1'b0;
    repeat (40) step();
    chk("auto_off", 64'(bus.o_Sel), 64'd2);

    // Reset while issuing
    chk("pre_rst_drop", 64'(bus.o_Drop_Count), 64'd2);
    strobe(2, 64'h1234_5678_9ABC_DEF0, 8'hC3);
    step();
    chk("pre_rst_valid", 64'(bus.o_Valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.o_Valid), 64'd0);
    chk("arst_seg", bus.o_Segments, 64'd0);
    chk("arst_leds", 64'(bus.o_Leds), 64'd0);
    chk("arst_sel", 64'(bus.o_Sel), 64'd6);
    chk("arst_drop", 64'(bus.o_Drop_Count), 64'd0);
    #2;
    rst = 1'b0;
    count_valids(25, n);
    chk("post_rst_quiet", 64'(n), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tm1638_source_scheduler.md
Name: tm1638_source_scheduler

Overview:
- Shares the single tm1638_driver between NUM_SRC display sources: stimulus generators, key counters and key displays.
- Replaces the free-running select mux with a scheduled path: captures frames from the selected source, throttles them to the driver's pace and handles source switching by manual pulse or auto-rotate timer.
- Sits between the source instances and tm1638_driver in the tm1638 top level.

Parameters:
- NUM_SRC, 8, number of sources (2..16).
- INIT_SEL, 6, source selected after reset (< NUM_SRC).
- MIN_GAP_CYCLES, 16, minimum i_Clk cycles between consecutive o_Valid pulses (>= 1).
- AUTO_CYCLES, 27_000_000, auto-rotate period in cycles when i_Auto_En = 1 (>= 2).
- BLANK_ON_SWITCH, 1, when 1 an all-zero frame is issued on every selection change.

Ports:
- i_Clk  input  1  system clock
- i_Rst  input  1  asynchronous, active-high reset
- i_Segments  input  NUM_SRC x segments_t  per-source segment frames
- i_Leds  input  NUM_SRC x leds_t  per-source LED frames
- i_Valid  input  NUM_SRC  per-source one-cycle frame-valid strobes
- i_Next  input  1  one-cycle pulse: advance selection (already debounced/pulsed)
- i_Auto_En  input  1  level: enable auto-rotation
- i_Driver_Busy  input  1  high while the driver is serialising a frame or the SPI FIFO is full
- o_Segments  output  segments_t  frame to driver
- o_Leds  output  leds_t  LEDs to driver
- o_Valid  output  1  one-cycle frame strobe to driver
- o_Sel  output  $clog2(NUM_SRC)  current selection
- o_Drop_Count  output  16  saturating count of overwritten pending frames

Behaviour:
- Reset values (asynchronous): o_Segments = 0, o_Leds = 0, o_Valid = 0, o_Sel = INIT_SEL, o_Drop_Count = 0, pending flag = 0, gap counter = 0, auto counter = 0, FSM = S_IDLE.
- Selection:
  - Advances by exactly 1, mod NUM_SRC (NUM_SRC-1 -> 0), on i_Next or on auto tick.
  - Auto tick: auto counter reaches AUTO_CYCLES-1 while i_Auto_En = 1.
  - Auto counter clears on any advance and whenever i_Auto_En = 0.
  - i_Next and auto tick in the same cycle -> single advance.
- Capture: i_Valid[o_Sel] = 1 latches i_Segments/i_Leds[o_Sel] into the pending buffer and sets pending.
  - Capture while pending is already set -> overwrite (latest wins), o_Drop_Count += 1, saturating at 16'hFFFF.
  - Strobes from non-selected sources are ignored.
- Switch, in the cycle selection changes:
  - Any pending frame is discarded, with no drop count.
  - A valid strobe from the old source in that same cycle is ignored.
  - If BLANK_ON_SWITCH = 1, pending is loaded with an all-zero frame.
  - The new source's strobe is honoured from the next cycle.
- FSM:
  - S_IDLE: pending = 1 and i_Driver_Busy = 0 -> S_ISSUE.
  - S_ISSUE, one cycle: o_Segments/o_Leds <= pending buffer, o_Valid = 1, pending cleared, gap counter loaded with MIN_GAP_CYCLES-1 -> S_GAP.
    - A capture in the S_ISSUE cycle sets pending for the next frame and is not counted as a drop.
  - S_GAP: counter decrements; at 0 -> S_IDLE. Captures continue into the pending buffer.
- Output timing:
  - Latency from capture to o_Valid is 2 cycles minimum (capture registered, then S_ISSUE).
  - o_Segments/o_Leds are held stable between issues.
  - Consecutive o_Valid pulses are at least MIN_GAP_CYCLES+1 cycles apart.
- i_Driver_Busy asserted during S_IDLE stalls issuance indefinitely. Pending keeps updating (with drops counted).
- Reset asserted mid-frame: o_Valid drops asynchronously. No partial state is retained.

Decomposition:
- Add to tm1638_types:
  - sched_state_t enum {S_IDLE, S_ISSUE, S_GAP}.
  - frame_t struct {segments_t seg; leds_t leds}.
- One natural sub-module: tm1638_sel_rotator, containing the selection register, auto-rotate counter and i_Next merge, and outputting sel plus a one-cycle switch strobe.

Test Plan:
- Reset with INIT_SEL = 6; strobe i_Valid[6] with seg pattern A -> o_Valid exactly 2 cycles later, o_Segments = A, o_Sel = 6.
- Strobe i_Valid[6] twice 3 cycles apart with MIN_GAP_CYCLES = 16, Busy = 0 -> second o_Valid 17 cycles after the first; o_Drop_Count = 0.
- Busy held 1; three strobes on source 6 (A, B, C) -> no o_Valid, o_Drop_Count = 2; release Busy -> a single o_Valid carrying C.
- i_Next pulse at o_Sel = 7 (NUM_SRC = 8), BLANK_ON_SWITCH = 1 -> o_Sel = 0, an all-zero frame is issued, a source-7 strobe in the same cycle is ignored.
- i_Auto_En = 1, AUTO_CYCLES = 10, i_Next coincident with the 10th cycle -> o_Sel advances by exactly 1, next auto advance 10 cycles later.
- Assert i_Rst during S_ISSUE -> o_Valid falls immediately, all outputs at reset values, o_Sel = INIT_SEL.
